// File: rtl/feature_store_writer.sv
// Serialises wide MAC result vectors into narrow feature-map RAM beats at
// consecutive addresses, through a two-entry ping-pong buffer with optional ReLU.
module feature_store_writer #(
    parameter int unsigned MAC_NUM = 112,
    parameter int unsigned DW      = 17,
    parameter int unsigned LANES   = 4,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned CNT_W   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [CNT_W-1:0]         num_vectors,
    input  logic                     relu_en,
    input  logic                     in_vld,
    input  logic [MAC_NUM*DW-1:0]    in_data,
    output logic                     in_rdy,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LANES*DW-1:0]      mem_wdata,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned BEATS   = (MAC_NUM + LANES - 1) / LANES;
    localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned VEC_DW  = MAC_NUM * DW;
    localparam int unsigned BEAT_DW = LANES * DW;
    localparam int unsigned PAD_DW  = BEATS * BEAT_DW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_num;
    logic                r_relu;
    logic [CNT_W-1:0]    r_acc_cnt;
    logic [CNT_W-1:0]    r_wr_cnt;
    logic [1:0]          r_occ;
    logic                r_wptr;
    logic                r_rptr;
    logic [BEAT_W-1:0]   r_beat;
    logic [ADDR_W-1:0]   r_total;
    logic [VEC_DW-1:0]   r_buf [2];

    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [BEAT_DW-1:0]  r_mem_wdata;
    logic                r_busy;
    logic                r_done;

    logic                w_rdy;
    logic                w_push;
    logic                w_issue;
    logic                w_pop;
    logic [PAD_DW-1:0]   w_pad;
    logic [BEAT_DW-1:0]  w_beat;

    // Next-state and handshake decode; in_rdy depends on registered state only.
    always_comb begin
        w_state_nxt = r_state;
        w_rdy       = (r_state == S_RUN) && (r_occ < 2'd2) && (r_acc_cnt < r_num);
        w_push      = in_vld && w_rdy;
        w_issue     = (r_state == S_RUN) && (r_occ != 2'd0);
        w_pop       = w_issue && (r_beat == BEAT_W'(BEATS - 1));
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_vectors == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (r_wr_cnt == r_num) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Beat select from the head entry, zero-padding lanes past MAC_NUM, then ReLU.
    always_comb begin
        w_pad             = '0;
        w_pad[VEC_DW-1:0] = r_buf[r_rptr];
        w_beat            = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (r_beat == BEAT_W'(b)) begin
                w_beat = w_pad[b*BEAT_DW +: BEAT_DW];
            end
        end
        for (int k = 0; k < LANES; k++) begin
            if (r_relu && w_beat[k*DW + DW - 1]) begin
                w_beat[k*DW +: DW] = '0;
            end
        end
    end

    // State, job parameters, buffer bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_num       <= '0;
            r_relu      <= 1'b0;
            r_acc_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_occ       <= 2'd0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_beat      <= '0;
            r_total     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && start) begin
                r_base    <= base_addr;
                r_num     <= num_vectors;
                r_relu    <= relu_en;
                r_acc_cnt <= '0;
                r_wr_cnt  <= '0;
                r_occ     <= 2'd0;
                r_wptr    <= 1'b0;
                r_rptr    <= 1'b0;
                r_beat    <= '0;
                r_total   <= '0;
            end else begin
                if (w_push) begin
                    r_wptr    <= ~r_wptr;
                    r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                end
                if (w_issue) begin
                    r_total <= r_total + ADDR_W'(1);
                    r_beat  <= w_pop ? '0 : r_beat + BEAT_W'(1);
                end
                if (w_pop) begin
                    r_rptr   <= ~r_rptr;
                    r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_occ <= r_occ + 2'd1;
                    2'b01:   r_occ <= r_occ - 2'd1;
                    default: r_occ <= r_occ;
                endcase
            end
            r_mem_we <= w_issue;
            if (w_issue) begin
                r_mem_addr  <= r_base + r_total;
                r_mem_wdata <= w_beat;
            end
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_FIN);
        end
    end

    // Payload storage carries no reset; validity is tracked by r_occ.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wptr] <= in_data;
        end
    end

    assign in_rdy    = w_rdy;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_feature_store_writer.sv
// Directed bench for feature_store_writer: a 112x4 instance for most jobs and
// a 100x8 instance for the partial-beat / address-wrap case.
module tb_feature_store_writer;

    localparam int unsigned DW      = 17;
    localparam int unsigned AW      = 12;
    localparam int unsigned CW      = 10;
    localparam int unsigned A_MAC   = 112;
    localparam int unsigned A_LN    = 4;
    localparam int unsigned A_BEATS = 28;
    localparam int unsigned B_MAC   = 100;
    localparam int unsigned B_LN    = 8;
    localparam int unsigned B_BEATS = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic                  a_start = 1'b0;
    logic [AW-1:0]         a_base  = '0;
    logic [CW-1:0]         a_num   = '0;
    logic                  a_relu  = 1'b0;
    logic                  a_in_vld = 1'b0;
    logic [A_MAC*DW-1:0]   a_in_data = '0;
    logic                  a_in_rdy;
    logic                  a_mem_we;
    logic [AW-1:0]         a_mem_addr;
    logic [A_LN*DW-1:0]    a_mem_wdata;
    logic                  a_busy;
    logic                  a_done;

    logic                  b_start = 1'b0;
    logic [AW-1:0]         b_base  = '0;
    logic [CW-1:0]         b_num   = '0;
    logic                  b_relu  = 1'b0;
    logic                  b_in_vld = 1'b0;
    logic [B_MAC*DW-1:0]   b_in_data = '0;
    logic                  b_in_rdy;
    logic                  b_mem_we;
    logic [AW-1:0]         b_mem_addr;
    logic [B_LN*DW-1:0]    b_mem_wdata;
    logic                  b_busy;
    logic                  b_done;

    feature_store_writer #(
        .MAC_NUM(A_MAC), .DW(DW), .LANES(A_LN), .ADDR_W(AW), .CNT_W(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .start(a_start), .base_addr(a_base),
        .num_vectors(a_num), .relu_en(a_relu), .in_vld(a_in_vld),
        .in_data(a_in_data), .in_rdy(a_in_rdy), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .busy(a_busy),
        .done(a_done)
    );

    feature_store_writer #(
        .MAC_NUM(B_MAC), .DW(DW), .LANES(B_LN), .ADDR_W(AW), .CNT_W(CW)
    ) u_dut8 (
        .clk(clk), .rst(rst), .start(b_start), .base_addr(b_base),
        .num_vectors(b_num), .relu_en(b_relu), .in_vld(b_in_vld),
        .in_data(b_in_data), .in_rdy(b_in_rdy), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .busy(b_busy),
        .done(b_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitors sample on the falling edge.
    logic [AW-1:0]      qa_addr[$];
    logic [A_LN*DW-1:0] qa_data[$];
    int                 qa_cyc[$];
    logic [AW-1:0]      qb_addr[$];
    logic [B_LN*DW-1:0] qb_data[$];

    always @(negedge clk) begin
        if (a_mem_we) begin
            qa_addr.push_back(a_mem_addr);
            qa_data.push_back(a_mem_wdata);
            qa_cyc.push_back(cyc);
        end
        if (b_mem_we) begin
            qb_addr.push_back(b_mem_addr);
            qb_data.push_back(b_mem_wdata);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cyc[$];
    int extra_rdy   = 0;
    int g_start_cyc = 0;
    int g_done_cyc  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_val(input int pat, input int v, input int j);
        if (pat == 0) return DW'(v * 128 + j);
        return ((j % 2) == 0) ? 17'h1FFFF : 17'h0000F;
    endfunction

    function automatic logic [A_MAC*DW-1:0] vec_a(input int pat, input int v);
        logic [A_MAC*DW-1:0] r;
        r = '0;
        for (int j = 0; j < A_MAC; j++) r[j*DW +: DW] = lane_val(pat, v, j);
        return r;
    endfunction

    function automatic logic [A_LN*DW-1:0] exp_beat_a(input int pat, input logic relu, input int t);
        logic [A_LN*DW-1:0] r;
        logic [DW-1:0]      l;
        int                 v;
        int                 b;
        v = t / A_BEATS;
        b = t % A_BEATS;
        r = '0;
        for (int k = 0; k < A_LN; k++) begin
            l = lane_val(pat, v, b * A_LN + k);
            if (relu && l[DW-1]) l = '0;
            r[k*DW +: DW] = l;
        end
        return r;
    endfunction

    task automatic start_a(input logic [AW-1:0] base, input logic [CW-1:0] num,
                           input logic relu, input bit poke);
        qa_addr.delete(); qa_data.delete(); qa_cyc.delete(); acc_cyc.delete();
        @(negedge clk);
        a_start = 1'b1; a_base = base; a_num = num; a_relu = relu;
        g_start_cyc = cyc;
        @(negedge clk);
        a_start = 1'b0; a_base = '0; a_num = '0; a_relu = 1'b0;
        if (poke) begin
            check("busy_before_restart", a_busy, 1);
            a_start = 1'b1; a_base = 12'h200; a_num = 10'd5; a_relu = ~relu;
            @(negedge clk);
            a_start = 1'b0; a_base = '0; a_num = '0; a_relu = 1'b0;
        end
    endtask

    task automatic feed_a(input int num, input int pat);
        int acc;
        int t;
        acc = 0;
        t = 0;
        while (acc < num && t < 500) begin
            a_in_data = vec_a(pat, acc);
            a_in_vld  = 1'b1;
            if (a_in_rdy) begin
                acc_cyc.push_back(cyc);
                acc++;
            end
            @(negedge clk);
            t++;
        end
        check("accepted_vectors", acc, num);
    endtask

    task automatic wait_done_a();
        int t;
        t = 0;
        extra_rdy = 0;
        while (!a_done && t < 3000) begin
            if (a_in_rdy) extra_rdy++;
            @(negedge clk);
            t++;
        end
        check("done_seen", a_done, 1);
        check("busy_at_done", a_busy, 0);
        g_done_cyc = cyc;
        a_in_vld = 1'b0;
        @(negedge clk);
        check("done_one_cycle", a_done, 0);
    endtask

    task automatic verify_a(input logic [AW-1:0] base, input int num, input logic relu, input int pat);
        int n;
        n = num * A_BEATS;
        check("write_count", qa_addr.size(), n);
        check("rdy_after_last_accept", extra_rdy, 0);
        for (int i = 0; i < qa_addr.size() && i < n; i++) begin
            check("addr", qa_addr[i], AW'(int'(base) + i));
            check("wdata", qa_data[i], exp_beat_a(pat, relu, i));
            check("gapless", qa_cyc[i] - qa_cyc[0], i);
        end
        if (n > 0 && qa_addr.size() > 0 && acc_cyc.size() > 0) begin
            check("first_write_latency", qa_cyc[0] - acc_cyc[0], 2);
            check("done_after_last_write", g_done_cyc - qa_cyc[qa_cyc.size()-1], 1);
        end
    endtask

    task automatic run_a(input logic [AW-1:0] base, input int num, input logic relu,
                         input int pat, input bit poke);
        start_a(base, CW'(num), relu, poke);
        feed_a(num, pat);
        wait_done_a();
        verify_a(base, num, relu, pat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [B_LN*DW-1:0] eb;
        logic [DW-1:0]      bl;
        logic [B_LN*DW-1:0] hi_part;
        int                 t;
        bit                 found;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_we", a_mem_we, 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_mem_wdata", a_mem_wdata, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_in_rdy", a_in_rdy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single vector, lane j = j, base 0x010
        run_a(12'h010, 1, 1'b0, 0, 1'b0);
        if (qa_data.size() > 0) check("beat0_wdata", qa_data[0], {17'd3, 17'd2, 17'd1, 17'd0});
        if (qa_addr.size() > 0) check("last_addr", qa_addr[qa_addr.size()-1], 12'h02B);

        // Back-to-back, three vectors with in_vld held high
        run_a(12'h123, 3, 1'b0, 0, 1'b0);
        if (acc_cyc.size() == 3) begin
            check("second_accept_gap", acc_cyc[1] - acc_cyc[0], 1);
            check("third_accept_at_pop", acc_cyc[2] - acc_cyc[0], A_BEATS + 1);
        end

        // ReLU on, then off
        run_a(12'h300, 1, 1'b1, 1, 1'b0);
        run_a(12'h300, 1, 1'b0, 1, 1'b0);

        // Partial last beat and address wrap on the 100x8 instance
        qb_addr.delete(); qb_data.delete();
        @(negedge clk);
        b_start = 1'b1; b_base = 12'hFF8; b_num = 10'd1; b_relu = 1'b0;
        for (int j = 0; j < B_MAC; j++) b_in_data[j*DW +: DW] = DW'(j + 1);
        @(negedge clk);
        b_start = 1'b0;
        b_in_vld = 1'b1;
        t = 0;
        while (!b_in_rdy && t < 50) begin @(negedge clk); t++; end
        check("b_accept_seen", b_in_rdy, 1);
        @(negedge clk);
        b_in_vld = 1'b0;
        t = 0;
        while (!b_done && t < 200) begin @(negedge clk); t++; end
        check("b_done_seen", b_done, 1);
        @(negedge clk);
        check("b_write_count", qb_addr.size(), B_BEATS);
        for (int i = 0; i < qb_addr.size() && i < B_BEATS; i++) begin
            eb = '0;
            for (int k = 0; k < B_LN; k++) begin
                bl = (i * B_LN + k < B_MAC) ? DW'(i * B_LN + k + 1) : '0;
                eb[k*DW +: DW] = bl;
            end
            check("b_addr", qb_addr[i], AW'(12'hFF8 + i));
            check("b_wdata", qb_data[i], eb);
        end
        if (qb_addr.size() == B_BEATS) begin
            hi_part = qb_data[12] >> (4 * DW);
            check("b_beat12_upper_zero", hi_part, 0);
            check("b_wrap_addr", qb_addr[8], 12'h000);
        end

        // num=0: done on the cycle after start, no writes
        run_a(12'h055, 0, 1'b0, 0, 1'b0);
        check("zero_done_latency", g_done_cyc - g_start_cyc, 1);

        // Second start while busy is ignored
        run_a(12'h100, 1, 1'b0, 1, 1'b1);

        // Reset at beat 10 of the second vector
        start_a(12'h040, 10'd2, 1'b0, 1'b0);
        feed_a(2, 0);
        found = 1'b0;
        t = 0;
        while (!found && t < 500) begin
            if (a_mem_we && a_mem_addr == 12'h066) found = 1'b1;
            else begin @(negedge clk); t++; end
        end
        check("rst_point_reached", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_mem_we", a_mem_we, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_in_rdy", a_in_rdy, 0);
        check("midrst_done", a_done, 0);
        rst = 1'b0;
        a_in_vld = 1'b0;
        @(negedge clk);
        run_a(12'h040, 1, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/feature_store_writer.md
Name: feature_store_writer

Overview:
- Downstream end of the MAC result path: accepts packed MAC_NUM-lane 17-bit saturated results (the store_data_17 stream) and writes them to feature-map BRAM.
- Each wide vector is serialised into LANES-lane memory beats at consecutive addresses from a programmed base.
- Two-entry ping-pong holding buffer with valid/ready input handshake; optional ReLU on write.
- Sits between the output buffer stage and the feature-map RAM that the next layer's input loader reads.

Parameters:
- MAC_NUM, 112, lanes per input vector (`MAC_NUM from def_header.vh).
- DW, 17, bits per lane.
- LANES, 4, lanes per memory beat; BEATS = ceil(MAC_NUM/LANES).
- ADDR_W, 12, memory address width.
- CNT_W, 10, width of the vector-count field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a job (ignored unless IDLE).
- base_addr  in  ADDR_W  first write address, sampled at start.
- num_vectors  in  CNT_W  vectors in job, sampled at start.
- relu_en  in  1  clamp negative lanes to 0, sampled at start.
- in_vld  in  1  in_data valid.
- in_data  in  MAC_NUM*DW  lane j at [j*DW +: DW], two's complement.
- in_rdy  out  1  writer can accept a vector this cycle.
- mem_we  out  1  write strobe, registered.
- mem_addr  out  ADDR_W  write address, registered.
- mem_wdata  out  LANES*DW  beat data, registered; lane k of beat b = input lane b*LANES+k.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last beat is written.

Behaviour:
- Reset: all outputs 0. State IDLE. Buffer empty, counters 0.
- States:
  - IDLE: on start, latch base_addr, num_vectors and relu_en. Go to RUN, or go to FIN if num_vectors==0.
  - RUN: accept and write vectors.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- Input acceptance:
  - in_rdy = (state==RUN) && (occupancy<2) && (accepted<num_vectors).
  - A transfer occurs when in_vld && in_rdy.
  - in_rdy is combinational from registered state only; it never depends on in_vld.
- Buffer:
  - Two entries, written alternately via a write pointer; read alternately via a read pointer.
  - A push and a pop in the same cycle are both legal; occupancy is unchanged.
- Writer:
  - When occupancy>0, one beat is issued per cycle, with no bubbles between beats or between back-to-back vectors.
  - Beat b of the head entry is registered into mem_wdata, with mem_we=1 and mem_addr=base+total_beats, one cycle after issue.
  - After beat BEATS-1 the head entry is popped.
  - Earliest first mem_we is 2 cycles after the accepting edge (1 cycle to buffer, 1 cycle output register).
- Partial last beat: lanes with index >= MAC_NUM are written as 0.
- ReLU: if relu_en and lane bit DW-1 == 1, the lane is written as 0. Otherwise the lane passes unchanged. No other arithmetic is applied.
- Address wraps modulo 2^ADDR_W with no error.
- Termination: when written vectors == num_vectors and the last mem_we has been issued, go to FIN. done asserts in the cycle after the last mem_we.
- start while busy: ignored, no parameter change.
- rst mid-job: immediate return to IDLE. In-flight beats are discarded; mem_we=0 on the following cycle.
- in_vld while not in RUN: ignored, since in_rdy=0.

Test Plan:
1. Single vector, MAC_NUM=112, LANES=4. start with base=0x010, num=1; lane j = j. Expect 28 consecutive mem_we at 0x010..0x02B. Beat 0 wdata = {3,2,1,0}. done 1 cycle after the 0x02B write.
2. Back-to-back: num=3, in_vld held high. Expect in_rdy to fall after 2 accepts and rise at the first pop. Expect 84 gapless writes at base..base+83, then in_rdy=0 for the rest of the job.
3. ReLU: relu_en=1, lanes alternate 0x1FFFF and 0x0000F. Expect every written lane to be 0x00000 or 0x0000F. Repeat with relu_en=0 and expect 0x1FFFF preserved.
4. Partial beat and wrap: MAC_NUM=100, LANES=8, base=0xFF8, num=1. Expect 13 beats at addresses 0xFF8..0xFFF, then 0x000..0x004. Beat 12 upper 4 lanes = 0.
5. Degenerate and control: num=0 gives done on the cycle after start and no mem_we. A second start during busy has no effect.
6. Reset mid-job: assert rst at beat 10 of vector 1. Expect mem_we=0 next cycle, busy=0, in_rdy=0. A fresh job after reset completes normally from base.
